i2c_game_slave: RTL and testbench

//  Player-board I2C target: downstream consumer of the game-side I2C master's REG_WRITE frames.

---
 rtl/i2c_game_pkg.sv | 39 +++
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_game_slave.sv | 133 +++++++++++++
 tb/tb_i2c_game_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_game_pkg.sv
// Shared definitions for the player-board I2C target: bus addresses,
// register addresses, register value encodings and the target FSM states.
package i2c_game_pkg;

    localparam logic [6:0] P1_ADDR = 7'b1010_101;
    localparam logic [6:0] P2_ADDR = 7'b0101_010;

    localparam logic [7:0] REG0_ADDR = 8'h00;
    localparam logic [7:0] REG1_ADDR = 8'h01;
    localparam logic [7:0] REG2_ADDR = 8'h02;

    // reg0: current lead
    localparam logic [7:0] CUR_TIE    = 8'd0;
    localparam logic [7:0] CUR_LEAD   = 8'd1;
    localparam logic [7:0] CUR_BEHIND = 8'd2;

    // reg1: match result
    localparam logic [7:0] GAME_NONE = 8'd0;
    localparam logic [7:0] GAME_DRAW = 8'd1;
    localparam logic [7:0] GAME_WIN  = 8'd2;
    localparam logic [7:0] GAME_LOSE = 8'd3;

    // reg2: ladder event
    localparam logic [7:0] LADDER_NONE = 8'd0;
    localparam logic [7:0] LADDER_DOWN = 8'd1;
    localparam logic [7:0] LADDER_UP   = 8'd2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_slv_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and produces one-cycle pulses
// for SCL edges and START/STOP conditions.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_prev;
    logic                   sda_prev;

    // Synchroniser chains plus one delayed copy for edge detection; idle bus reads high
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Edge and bus-condition pulses; START/STOP need SCL high on both samples
    always_comb begin
        scl_rise  = scl_s & ~scl_prev;
        scl_fall  = ~scl_s & scl_prev;
        start_det = scl_s & scl_prev & sda_prev & ~sda_s;
        stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;
    end

endmodule

// File: rtl/i2c_game_slave.sv
// Write-only I2C target holding the three game registers. Decodes
// START/addr+W/reg/data.../STOP frames, ACKs its own address and every
// following byte, and strobes wr_stb for each committed register write.
module i2c_game_slave
    import i2c_game_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = P1_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] reg0_q,
    output logic [7:0] reg1_q,
    output logic [7:0] reg2_q,
    output logic [2:0] wr_stb,
    output logic       busy
);

    i2c_slv_state_t state, state_nxt;

    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [3:0] bit_cnt;
    logic [6:0] shift_q;
    logic [7:0] reg_ptr;
    logic       sda_oe;
    logic [7:0] byte_in;
    logic       byte_done;
    logic       in_ack;
    logic       ack_end;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (SCL),
        .sda_in   (SDA),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Byte assembly and slot decode shared by FSM and datapath
    always_comb begin
        byte_in   = {shift_q, sda_s};
        byte_done = scl_rise && (bit_cnt == 4'd7);
        in_ack    = (state == ADDR_ACK) || (state == REG_ACK) || (state == DATA_ACK);
        // an ACK slot ends on the second SCL fall, i.e. while we are driving
        ack_end   = in_ack && scl_fall && sda_oe;
        busy      = (state != IDLE) && (state != IGNORE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; STOP/START override every state
    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:     if (byte_done) state_nxt = (byte_in == {SLAVE_ADDR, 1'b0}) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (ack_end)   state_nxt = REG;
                REG:      if (byte_done) state_nxt = REG_ACK;
                REG_ACK:  if (ack_end)   state_nxt = DATA;
                DATA:     if (byte_done) state_nxt = DATA_ACK;
                DATA_ACK: if (ack_end)   state_nxt = DATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // Bit counter, shifter, ACK driver, register pointer and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
            reg_ptr <= '0;
            sda_oe  <= 1'b0;
            reg0_q  <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            wr_stb  <= '0;
        end else begin
            wr_stb <= '0;
            if (stop_det || start_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                if (in_ack) begin
                    // first fall (end of bit 8) starts the low drive, second fall ends it
                    if (scl_fall) begin
                        sda_oe <= ~sda_oe;
                        if (sda_oe) bit_cnt <= '0;
                    end
                end else if (scl_rise && ((state == ADDR) || (state == REG) || (state == DATA))) begin
                    shift_q <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 4'd1;
                end

                if ((state == REG) && byte_done) reg_ptr <= byte_in;

                if ((state == DATA) && byte_done) begin
                    case (reg_ptr)
                        REG0_ADDR: begin reg0_q <= byte_in; wr_stb <= 3'b001; end
                        REG1_ADDR: begin reg1_q <= byte_in; wr_stb <= 3'b010; end
                        REG2_ADDR: begin reg2_q <= byte_in; wr_stb <= 3'b100; end
                        default:   ;
                    endcase
                end

                if ((state == DATA_ACK) && ack_end) reg_ptr <= reg_ptr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_game_slave.sv
// Bench for i2c_game_slave: a bit-banged I2C master drives directed and
// random frames; a frame-level register model predicts registers, strobes,
// ACK/NACK bits and the number of target ACK pulses on SDA.
module tb_i2c_game_slave;
    import i2c_game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    wire        sda_bus;
    logic [7:0] reg0_q, reg1_q, reg2_q;
    logic [2:0] wr_stb;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = m_oe ? 1'b0 : 1'bz;

    i2c_game_slave #(
        .SLAVE_ADDR (P1_ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .SCL   (scl),
        .SDA   (sda_bus),
        .reg0_q(reg0_q),
        .reg1_q(reg1_q),
        .reg2_q(reg2_q),
        .wr_stb(wr_stb),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mreg [3];
    logic [7:0] fb   [4];

    // observed strobe events and target ACK pulses
    logic [2:0] stb_q [$];
    logic [7:0] stbv_q[$];
    int         ack_pulses = 0;
    logic       dl_q = 1'b0;

    always @(negedge clk) begin
        logic dl;
        if (wr_stb !== 3'b000) begin
            stb_q.push_back(wr_stb);
            stbv_q.push_back(wr_stb[0] ? reg0_q : wr_stb[1] ? reg1_q : reg2_q);
        end
        dl = (sda_bus === 1'b0) && !m_oe;
        if (dl && !dl_q) ack_pulses++;
        dl_q = dl;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_oe = 1'b0; qwait();
        scl  = 1'b1; qwait();
        m_oe = 1'b1; qwait();
        scl  = 1'b0;
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; qwait();
        scl  = 1'b1; qwait();
        m_oe = 1'b0; qwait();
    endtask

    task automatic send_bit(input logic b);
        qwait();
        m_oe = !b; qwait();
        scl  = 1'b1; qwait(); qwait();
        scl  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        qwait();
        m_oe = 1'b0; qwait();
        scl  = 1'b1; qwait();
        ack  = sda_bus;
        qwait();
        scl  = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_reg0"}, reg0_q, mreg[0]);
        check({tag, "_reg1"}, reg1_q, mreg[1]);
        check({tag, "_reg2"}, reg2_q, mreg[2]);
    endtask

    // One full frame: fb[0] is the register pointer, fb[1..nb-1] the data bytes
    task automatic do_frame(input string tag, input logic [6:0] addr, input logic rw, input int nb);
        logic [7:0] ptr;
        logic       match;
        logic       ack;
        int         a0;
        logic [2:0] es[$];
        logic [7:0] ev[$];
        match = (addr == P1_ADDR) && !rw;
        if (match) begin
            ptr = fb[0];
            for (int i = 1; i < nb; i++) begin
                if (ptr < 8'd3) begin
                    mreg[ptr] = fb[i];
                    es.push_back(3'(1 << ptr[1:0]));
                    ev.push_back(fb[i]);
                end
                ptr = ptr + 8'd1;
            end
        end
        stb_q.delete();
        stbv_q.delete();
        a0 = ack_pulses;
        i2c_start();
        check({tag, "_busy_start"}, busy, 1);
        send_byte({addr, rw}, ack);
        check({tag, "_addr_ack"}, ack, !match);
        if (match) begin
            for (int i = 0; i < nb; i++) begin
                send_byte(fb[i], ack);
                check({tag, "_byte_ack"}, ack, 0);
            end
        end
        i2c_stop();
        qwait();
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_ack_pulses"}, ack_pulses - a0, match ? nb + 1 : 0);
        check({tag, "_nstb"}, stb_q.size(), es.size());
        for (int i = 0; i < es.size(); i++) begin
            if (i < stb_q.size()) begin
                check({tag, "_stb"}, stb_q[i], es[i]);
                check({tag, "_stbval"}, stbv_q[i], ev[i]);
            end
        end
        check_regs(tag);
    endtask

    initial begin
        logic       ack;
        logic       seen;
        int         sel;
        int         nb;
        logic [7:0] ptrs[6];
        ptrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFE, 8'hFF};
        for (int i = 0; i < 3; i++) mreg[i] = 8'h00;

        // reset state
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda_bus, 1);
        check_regs("rst");

        // 1: single write to reg0
        fb[0] = REG0_ADDR; fb[1] = CUR_LEAD;
        do_frame("t1", P1_ADDR, 1'b0, 2);

        // 2: foreign address is NACKed and ignored
        fb[0] = REG0_ADDR; fb[1] = CUR_BEHIND;
        do_frame("t2", P2_ADDR, 1'b0, 2);

        // 3: auto-increment reg1 then reg2
        fb[0] = REG1_ADDR; fb[1] = GAME_WIN; fb[2] = LADDER_DOWN;
        do_frame("t3", P1_ADDR, 1'b0, 3);

        // 4: out-of-range pointer, ACKed but discarded
        fb[0] = 8'h05; fb[1] = 8'hAA;
        do_frame("t4", P1_ADDR, 1'b0, 2);

        // read request is NACKed
        do_frame("rd", P1_ADDR, 1'b1, 1);

        // 5: STOP after 4 data bits, then an immediate valid frame
        stb_q.delete();
        i2c_start();
        send_byte({P1_ADDR, 1'b0}, ack);
        send_byte(REG2_ADDR, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        i2c_stop();
        check("t5_abort_nstb", stb_q.size(), 0);
        check("t5_abort_reg2", reg2_q, mreg[2]);
        fb[0] = REG2_ADDR; fb[1] = LADDER_UP;
        do_frame("t5", P1_ADDR, 1'b0, 2);

        // 6: reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(P1_ADDR[6:0] == 7'h00 ? 1'b0 : ((i == 0) ? 1'b0 : P1_ADDR[i-1]));
        qwait();
        m_oe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (sda_bus === 1'b0) seen = 1'b1;
        end
        check("t6_ack_drive_seen", seen, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_sda_released", sda_bus, 1);
        check("t6_busy", busy, 0);
        for (int i = 0; i < 3; i++) mreg[i] = 8'h00;
        check_regs("t6_rst");
        scl = 1'b1; qwait();
        scl = 1'b0; qwait();
        i2c_stop();
        fb[0] = REG0_ADDR; fb[1] = CUR_BEHIND; fb[2] = GAME_LOSE;
        do_frame("t6_after", P1_ADDR, 1'b0, 3);

        // random frames
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 3);
            nb  = $urandom_range(1, 4);
            fb[0] = ptrs[$urandom_range(0, 5)];
            for (int i = 1; i < 4; i++) fb[i] = 8'($urandom_range(0, 255));
            case (sel)
                2:       do_frame("rnd_p2", P2_ADDR, 1'b0, nb);
                3:       do_frame("rnd_rd", P1_ADDR, 1'b1, nb);
                default: do_frame("rnd_wr", P1_ADDR, 1'b0, nb);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit so the bench always ends
    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
